// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants, types and helpers for the 8-channel TDM transmitter.
//   NUM_CH      - number of multiplexed channels
//   SLOT_W      - slot counter width
//   slot_t      - slot index type
//   sel_t       - far-end demux select bits {s0,s1,s2}, s0 is the MSB
//   slot_to_sel - maps a slot index onto the select bits
package tdm_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SLOT_W = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef struct packed {
        logic s0;
        logic s1;
        logic s2;
    } sel_t;

    // Slot k is decoded at the far-end demux as y(k+1); s0 carries the MSB.
    function automatic sel_t slot_to_sel(input slot_t slot);
        sel_t sel;
        sel.s0 = slot[2];
        sel.s1 = slot[1];
        sel.s2 = slot[0];
        return sel;
    endfunction

endpackage

// File: rtl/tdm_chan_buf.sv
// tdm_chan_buf: one-entry holding buffer for a single TDM channel.
//   clk, rst_n - clock, asynchronous active-low reset
//   cap_data   - word offered by the producer
//   cap_valid  - producer offers a word; taken only while the buffer is empty
//   drain      - the slot scanner is emitting this channel's slot this edge
//   full       - buffer holds a word not yet transmitted
//   data       - buffered word
module tdm_chan_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] cap_data,
    input  logic         cap_valid,
    input  logic         drain,
    output logic         full,
    output logic [W-1:0] data
);

    // Capture wins over drain: a drain of an empty buffer on the capture edge
    // leaves the new word waiting for the next visit of this slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (cap_valid && !full) begin
            full <= 1'b1;
            data <= cap_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: 8-channel time-division multiplexing transmitter.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - slot-scan enable; the slot counter holds while low
//   ch_data    - channel k word at [k*W +: W]
//   ch_valid   - per-channel word offered
//   ch_ready   - per-channel holding buffer empty (combinational from full)
//   m          - serialized word, zero when m_valid is low
//   m_valid    - presented slot carries a word
//   s0, s1, s2 - presented slot index, s0 is the MSB
//   frame      - presented slot is slot 0
//   m_ready    - downstream accepts the presented slot
module tdm_mux8_tx
    import tdm_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_CH*W-1:0] ch_data,
    input  logic [NUM_CH-1:0]   ch_valid,
    output logic [NUM_CH-1:0]   ch_ready,
    output logic [W-1:0]        m,
    output logic                m_valid,
    output logic                s0,
    output logic                s1,
    output logic                s2,
    output logic                frame,
    input  logic                m_ready
);

    slot_t               slot;
    logic                out_busy;
    logic                adv;
    sel_t                sel_q;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   drain;
    logic [W-1:0]        hb [NUM_CH];
    logic [W-1:0]        drain_data;
    logic                drain_full;

    // Per-channel holding buffers
    for (genvar k = 0; k < NUM_CH; k++) begin : g_buf
        tdm_chan_buf #(.W(W)) u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .cap_data  (ch_data[k*W +: W]),
            .cap_valid (ch_valid[k]),
            .drain     (drain[k]),
            .full      (full[k]),
            .data      (hb[k])
        );
    end

    assign ch_ready = ~full;

    // Every slot, idle or not, gets one handshake; an empty output register
    // never blocks the scan.
    assign adv = en && (!out_busy || m_ready);

    // Drain select and 8:1 mux for the slot being loaded
    always_comb begin
        drain      = '0;
        drain_full = full[slot];
        drain_data = hb[slot];
        if (adv) begin
            drain[slot] = 1'b1;
        end
    end

    // Slot counter and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= '0;
            out_busy <= 1'b0;
            sel_q    <= '0;
            m        <= '0;
            m_valid  <= 1'b0;
            frame    <= 1'b0;
        end else if (adv) begin
            sel_q    <= slot_to_sel(slot);
            m_valid  <= drain_full;
            m        <= drain_full ? drain_data : '0;
            frame    <= (slot == slot_t'(0));
            out_busy <= 1'b1;
            slot     <= slot + slot_t'(1);
        end else if (out_busy && m_ready) begin
            // Scan paused: the accepted slot retires and the line goes idle,
            // select and frame keep pointing at the last presented slot.
            m_valid  <= 1'b0;
            m        <= '0;
            out_busy <= 1'b0;
        end
    end

    assign s0 = sel_q.s0;
    assign s1 = sel_q.s1;
    assign s2 = sel_q.s2;

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// tb_tdm_mux8_tx: directed self-checking bench for tdm_mux8_tx.
module tb_tdm_mux8_tx;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [63:0] ch_data;
    logic [7:0]  ch_valid;
    logic [7:0]  ch_ready;
    logic [7:0]  m;
    logic        m_valid;
    logic        s0;
    logic        s1;
    logic        s2;
    logic        frame;
    logic        m_ready;
    logic [2:0]  sel;

    int checks = 0;
    int passed = 0;

    assign sel = {s0, s1, s2};

    tdm_mux8_tx #(.W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .m        (m),
        .m_valid  (m_valid),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .frame    (frame),
        .m_ready  (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        m_ready  = 1'b1;
        ch_valid = 8'h00;
        ch_data  = 64'h0;
        #3;
        checks++;
        if (ch_ready !== 8'hFF) $display("FAIL reset_ready: got %h want ff", ch_ready);
        else passed++;
        checks++;
        if (m !== 8'h00 || m_valid !== 1'b0 || sel !== 3'd0 || frame !== 1'b0)
            $display("FAIL reset_out: m=%h v=%b sel=%0d frame=%b want all 0", m, m_valid, sel, frame);
        else passed++;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Idle scan: selects walk 0..7,0 with frame on slot 0
    task automatic test_idle_scan();
        logic [2:0] e;
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            e = 3'(i % 8);
            checks++;
            if (sel !== e || m_valid !== 1'b0 || m !== 8'h00 || frame !== (e == 3'd0))
                $display("FAIL idle_scan[%0d]: sel=%0d v=%b m=%h frame=%b want sel=%0d v=0 m=00 frame=%b",
                         i, sel, m_valid, m, frame, e, (e == 3'd0));
            else passed++;
        end
        checks++;
        if (ch_ready !== 8'hFF) $display("FAIL idle_ready: got %h want ff", ch_ready);
        else passed++;
    endtask

    // All channels loaded in one cycle, then one full frame drains them
    task automatic test_load_all();
        logic [2:0] e;
        en = 1'b0;
        for (int k = 0; k < 8; k++) ch_data[k*8 +: 8] = 8'hA0 + 8'(k);
        ch_valid = 8'hFF;
        tick();
        ch_valid = 8'h00;
        checks++;
        if (ch_ready !== 8'h00 || m_valid !== 1'b0 || sel !== 3'd0)
            $display("FAIL load_capture: ready=%h v=%b sel=%0d want 00 0 0", ch_ready, m_valid, sel);
        else passed++;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = 3'((i + 1) % 8);
            checks++;
            if (m !== 8'hA0 + 8'(e) || m_valid !== 1'b1 || sel !== e || frame !== (e == 3'd0))
                $display("FAIL load_slot[%0d]: m=%h v=%b sel=%0d frame=%b want m=%h v=1 sel=%0d",
                         e, m, m_valid, sel, frame, 8'hA0 + 8'(e), e);
            else passed++;
        end
        checks++;
        if (ch_ready !== 8'hFF) $display("FAIL load_drained: ready=%h want ff", ch_ready);
        else passed++;
    endtask

    // Word offered on the same edge its slot is scanned waits a full frame
    task automatic test_same_edge();
        logic [2:0] e;
        repeat (4) tick();
        checks++;
        if (sel !== 3'd4) $display("FAIL same_edge_align: sel=%0d want 4", sel);
        else passed++;
        ch_data[5*8 +: 8] = 8'h55;
        ch_valid = 8'h20;
        tick();
        ch_valid = 8'h00;
        checks++;
        if (sel !== 3'd5 || m_valid !== 1'b0 || ch_ready !== 8'hDF)
            $display("FAIL same_edge_idle: sel=%0d v=%b ready=%h want 5 0 df", sel, m_valid, ch_ready);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            tick();
            e = 3'((6 + i) % 8);
            checks++;
            if (sel !== e || m_valid !== 1'b0)
                $display("FAIL same_edge_gap[%0d]: sel=%0d v=%b want sel=%0d v=0", i, sel, m_valid, e);
            else passed++;
        end
        tick();
        checks++;
        if (m !== 8'h55 || m_valid !== 1'b1 || sel !== 3'd5 || ch_ready !== 8'hFF)
            $display("FAIL same_edge_word: m=%h v=%b sel=%0d ready=%h want 55 1 5 ff",
                     m, m_valid, sel, ch_ready);
        else passed++;
    endtask

    // Downstream stall on slot 2 freezes outputs and keeps slot 3 buffered
    task automatic test_backpressure();
        ch_data[2*8 +: 8] = 8'h22;
        ch_data[3*8 +: 8] = 8'h33;
        ch_valid = 8'h0C;
        tick();
        ch_valid = 8'h00;
        repeat (3) tick();
        tick();
        checks++;
        if (m !== 8'h22 || m_valid !== 1'b1 || sel !== 3'd2)
            $display("FAIL bp_present: m=%h v=%b sel=%0d want 22 1 2", m, m_valid, sel);
        else passed++;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (m !== 8'h22 || m_valid !== 1'b1 || sel !== 3'd2 || frame !== 1'b0 || ch_ready !== 8'hF7)
                $display("FAIL bp_hold[%0d]: m=%h v=%b sel=%0d frame=%b ready=%h want 22 1 2 0 f7",
                         i, m, m_valid, sel, frame, ch_ready);
            else passed++;
        end
        m_ready = 1'b1;
        tick();
        checks++;
        if (m !== 8'h33 || m_valid !== 1'b1 || sel !== 3'd3 || ch_ready !== 8'hFF)
            $display("FAIL bp_resume: m=%h v=%b sel=%0d ready=%h want 33 1 3 ff", m, m_valid, sel, ch_ready);
        else passed++;
        tick();
        checks++;
        if (sel !== 3'd4 || m_valid !== 1'b0)
            $display("FAIL bp_next: sel=%0d v=%b want 4 0", sel, m_valid);
        else passed++;
    endtask

    // Scan paused before slot 6; resuming continues at slot 6
    task automatic test_en_drop();
        tick();
        checks++;
        if (sel !== 3'd5) $display("FAIL en_align: sel=%0d want 5", sel);
        else passed++;
        en = 1'b0;
        ch_data[6*8 +: 8] = 8'h66;
        ch_valid = 8'h40;
        tick();
        ch_valid = 8'h00;
        checks++;
        if (m_valid !== 1'b0 || m !== 8'h00 || sel !== 3'd5 || ch_ready !== 8'hBF)
            $display("FAIL en_idle: v=%b m=%h sel=%0d ready=%h want 0 00 5 bf", m_valid, m, sel, ch_ready);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b0 || sel !== 3'd5)
                $display("FAIL en_hold[%0d]: v=%b sel=%0d want 0 5", i, m_valid, sel);
            else passed++;
        end
        en = 1'b1;
        tick();
        checks++;
        if (m !== 8'h66 || m_valid !== 1'b1 || sel !== 3'd6)
            $display("FAIL en_resume: m=%h v=%b sel=%0d want 66 1 6", m, m_valid, sel);
        else passed++;
        tick();
        checks++;
        if (sel !== 3'd7 || m_valid !== 1'b0)
            $display("FAIL en_next: sel=%0d v=%b want 7 0", sel, m_valid);
        else passed++;
    endtask

    // Asynchronous reset mid-frame discards buffered words
    task automatic test_async_reset();
        ch_data[1*8 +: 8] = 8'h11;
        ch_data[2*8 +: 8] = 8'h12;
        ch_data[3*8 +: 8] = 8'h13;
        ch_data[4*8 +: 8] = 8'h14;
        ch_valid = 8'h1E;
        tick();
        ch_valid = 8'h00;
        tick();
        checks++;
        if (m !== 8'h11 || m_valid !== 1'b1 || sel !== 3'd1 || ch_ready !== 8'hE3)
            $display("FAIL arst_pre: m=%h v=%b sel=%0d ready=%h want 11 1 1 e3", m, m_valid, sel, ch_ready);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ch_ready !== 8'hFF || m !== 8'h00 || m_valid !== 1'b0 || sel !== 3'd0 || frame !== 1'b0)
            $display("FAIL arst_now: ready=%h m=%h v=%b sel=%0d frame=%b want ff 00 0 0 0",
                     ch_ready, m, m_valid, sel, frame);
        else passed++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b0 || m !== 8'h00 || sel !== 3'(i % 8))
                $display("FAIL arst_after[%0d]: v=%b m=%h sel=%0d want 0 00 %0d", i, m_valid, m, sel, i % 8);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_all();
        test_same_edge();
        test_backpressure();
        test_en_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tdm_mux8_tx.md
# tdm_mux8_tx

Eight-channel time-division multiplexing transmitter. It accepts words from 8 independent producers over per-channel valid/ready handshakes and serializes them onto a single data line. Each word carries a 3-bit slot select `{s0,s1,s2}`, which drives the team's 1-to-8 select-decoding demultiplexer at the far end. Slot k (k = 0..7) is decoded there as output y(k+1).

## Interface
- `W`, default 8: data width per channel and of the serialized line.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: slot-scan enable; when low the slot counter holds.
- `ch_data` input, 8*W bits: channel k occupies bits [k*W +: W].
- `ch_valid` input, 8 bits: per-channel word offered.
- `ch_ready` output, 8 bits: per-channel holding buffer empty (`ch_ready[k] = ~full[k]`).
- `m` output, W bits: serialized data; zero when `m_valid` is 0.
- `m_valid` output, 1 bit: the current slot carries a word.
- `s0`, `s1`, `s2` outputs, 1 bit each: slot select, with slot index k = {s0,s1,s2} (s0 is the MSB).
- `frame` output, 1 bit: high when the presented slot is slot 0.
- `m_ready` input, 1 bit: downstream accepts the presented slot.

## Operation
- Per channel:
  - One-entry holding buffer `hb[k]` with flag `full[k]`.
  - Capture when `ch_valid[k] & ch_ready[k]`: `hb[k] <= data`, `full[k] <= 1`.
- Slot counter `slot`, 3 bits:
  - Advance condition `adv = en & (~out_busy | m_ready)`, where `out_busy` is the output register holding a slot not yet accepted.
  - Every slot, idle or not, is presented for one handshake.
- On `adv`:
  - Load the output register: `{s0,s1,s2} <= slot`, `m_valid <= full[slot]`, `m <= full[slot] ? hb[slot] : 0`, `frame <= (slot == 0)`.
  - Clear `full[slot]`.
  - `slot <= slot + 1`, wrapping 7 -> 0.
- When `en = 0` and the presented slot is accepted: the output register goes idle (`m_valid = 0`, `out_busy = 0`) and `slot` holds.
- Empty slots are transmitted as idle slots (`m_valid = 0`, `m = 0`). The fixed slot order is never compressed.
- Simultaneous capture and drain of the same channel k (`full[k] = 0`, `slot == k`, `ch_valid[k] = 1` on an `adv` edge):
  - The slot goes out idle.
  - The word is captured and leaves on the next visit to slot k, 8 advances later.
- Backpressure: while `m_ready = 0` with `out_busy = 1`, all outputs hold, `slot` holds, and no buffer drains. Capture into empty buffers continues.
- Reset, asynchronous and including mid-operation:
  - `slot = 0`, all `full = 0`, so `ch_ready = 8'hFF` immediately.
  - `m = 0`, `m_valid = 0`, `{s0,s1,s2} = 0`, `frame = 0`, `out_busy = 0`.
  - Buffered words are discarded.

## Timing
- `ch_ready` is combinational from `full` only. It has no path from `ch_valid` or `m_ready`.
- All other outputs are registered.
- Minimum latency: word captured at edge t, `slot == k` and `adv` at edge t+1 -> presented in the cycle after edge t+1.
- Maximum latency without backpressure and with `en = 1`: 8 advances.
- Throughput:
  - One slot per cycle at `m_ready = 1`.
  - One word per channel per 8 slots.
  - A full frame takes 8 cycles.

## Structure
- Package `tdm_pkg` holds:
  - `NUM_CH = 8` and `SLOT_W = 3`.
  - Typedef `slot_t` (logic [2:0]).
  - Function `slot_to_sel`, which maps a slot to `{s0,s1,s2}`.
- Sub-module `tdm_chan_buf`: the one-entry holding buffer with capture/drain ports and the `full` flag, instantiated 8 times.
- Top level: slot counter, drain mux (8:1 on `hb`/`full`), and output register.

## Test plan
- Reset release with `en = 1`, `m_ready = 1`, no `ch_valid` -> `ch_ready = 8'hFF`. Selects cycle 000,001,...,111,000. `m_valid = 0` throughout. `frame` is high every 8th cycle, on select 000.
- Load all 8 channels with data 8'hA0+k in one cycle, then run -> each slot k presents `m = 8'hA0+k`, `m_valid = 1`, select = k. After one frame, all `ch_ready` are back to 1.
- Offer channel 5 (8'h55) exactly on the edge where `slot == 5` advances -> slot 5 goes out idle. 8'h55 appears at the next slot-5 visit, 8 cycles later.
- Hold `m_ready = 0` for 4 cycles while slot 2 is presented with 8'h22 -> `m`, select, and `frame` are stable. Slot 3's buffer is not drained. Resumes in order on `m_ready = 1`.
- Drop `en` mid-frame at slot 6 -> after acceptance `m_valid = 0` and the select holds. Restoring `en` continues at slot 6 with no slot skipped.
- Assert `rst_n = 0` asynchronously with 3 buffers full and `m_valid = 1` -> all outputs 0 and `ch_ready = 8'hFF` before the next clock edge. No stale word appears after release.
